// File: rtl/bcd_byte_sequencer_if.sv
// Handshake/bus bundle for bcd_byte_sequencer.
// The optional abort input exists only when SEQ_ABORT_EN is defined.
interface bcd_byte_sequencer_if #(
  parameter int NUM_BYTES = 16
);
  localparam int IDXW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic                   start;
  logic [8*NUM_BYTES-1:0] block_in;
  logic                   busy;
  logic [11:0]            bcd_out;
  logic [IDXW-1:0]        byte_idx;
  logic                   out_valid;
  logic                   out_ready;
  logic                   done;
`ifdef SEQ_ABORT_EN
  logic                   abort;

  modport master (
    output start, block_in, out_ready, abort,
    input  busy, bcd_out, byte_idx, out_valid, done
  );

  modport slave (
    input  start, block_in, out_ready, abort,
    output busy, bcd_out, byte_idx, out_valid, done
  );
`else
  modport master (
    output start, block_in, out_ready,
    input  busy, bcd_out, byte_idx, out_valid, done
  );

  modport slave (
    input  start, block_in, out_ready,
    output busy, bcd_out, byte_idx, out_valid, done
  );
`endif
endinterface

// File: rtl/bcd_byte_sequencer.sv
// bcd_byte_sequencer: latches a block of bytes and converts each byte to
// 3-digit BCD using one shared shift-and-add-3 datapath (one bit per clock),
// streaming results over a valid/ready handshake.
// Optional feature macro: SEQ_ABORT_EN (adds an abort input on the interface).
module bcd_byte_sequencer #(
  parameter int NUM_BYTES = 16,
  parameter int MSB_FIRST = 1
) (
  input logic             clk,
  input logic             rst,
  bcd_byte_sequencer_if.slave bus
);
  localparam int IDXW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Carry-free digit correction: a nibble above 4 will exceed 9 after the
  // next doubling, so pre-add 3 to keep it a valid decimal digit.
  function automatic logic [3:0] add3_if_big(input logic [3:0] nib);
    return (nib > 4'd4) ? (nib + 4'd3) : nib;
  endfunction

  state_t                 state_r;
  logic [8*NUM_BYTES-1:0] shadow_r;
  logic [7:0]             cur_byte_r;
  logic [11:0]            scratch_r;
  logic [2:0]             bit_cnt_r;
  logic [IDXW-1:0]        byte_idx_r;
  logic [11:0]            bcd_out_r;
  logic                   busy_r;
  logic                   out_valid_r;
  logic                   done_r;

  logic [7:0]             sel_byte_s;
  logic [11:0]            shifted_s;
  logic [11:0]            next_scratch_s;
  logic                   abort_s;

`ifdef SEQ_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  assign bus.busy      = busy_r;
  assign bus.bcd_out   = bcd_out_r;
  assign bus.byte_idx  = byte_idx_r;
  assign bus.out_valid = out_valid_r;
  assign bus.done      = done_r;

  // Pick the shadow byte addressed by byte_idx, honouring byte ordering.
  always_comb begin
    sel_byte_s = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++) begin
      sel_byte_s = (byte_idx_r == IDXW'(k))
                 ? ((MSB_FIRST != 0) ? shadow_r[8*(NUM_BYTES-1-k) +: 8]
                                     : shadow_r[8*k +: 8])
                 : sel_byte_s;
    end
  end

  // One shift-and-add-3 iteration; the final bit is shifted without correction.
  always_comb begin
    shifted_s = {scratch_r[10:0], cur_byte_r[3'd7 - bit_cnt_r]};
    if (bit_cnt_r != 3'd7) begin
      next_scratch_s = {add3_if_big(shifted_s[11:8]),
                        add3_if_big(shifted_s[7:4]),
                        add3_if_big(shifted_s[3:0])};
    end else begin
      next_scratch_s = shifted_s;
    end
  end

  // Sequencer FSM with registered outputs; reset and abort take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      shadow_r    <= '0;
      cur_byte_r  <= 8'h00;
      scratch_r   <= 12'h000;
      bit_cnt_r   <= 3'd0;
      byte_idx_r  <= '0;
      bcd_out_r   <= 12'h000;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else if (abort_s && (state_r != S_IDLE)) begin
      state_r     <= S_IDLE;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            shadow_r   <= bus.block_in;
            byte_idx_r <= '0;
            busy_r     <= 1'b1;
            state_r    <= S_LOAD;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        S_LOAD: begin
          scratch_r  <= 12'h000;
          cur_byte_r <= sel_byte_s;
          bit_cnt_r  <= 3'd0;
          state_r    <= S_SHIFT;
        end
        S_SHIFT: begin
          scratch_r <= next_scratch_s;
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            bcd_out_r   <= next_scratch_s;
            out_valid_r <= 1'b1;
            state_r     <= S_OUT;
          end else begin
            state_r     <= S_SHIFT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (byte_idx_r == IDXW'(NUM_BYTES-1)) begin
              done_r  <= 1'b1;
              state_r <= S_DONE;
            end else begin
              byte_idx_r <= byte_idx_r + IDXW'(1);
              state_r    <= S_LOAD;
            end
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_byte_sequencer.sv
// Self-checking bench for bcd_byte_sequencer (NUM_BYTES=16, MSB_FIRST=1).
// Expected BCD comes from integer decimal arithmetic on the captured block.
module tb_bcd_byte_sequencer;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_byte_sequencer_if #(.NUM_BYTES(NB)) bus ();

  bcd_byte_sequencer #(.NUM_BYTES(NB), .MSB_FIRST(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [11:0] ref_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic int ref_byte(input logic [8*NB-1:0] blk, input int k);
    return int'(blk[8*(NB-1-k) +: 8]);
  endfunction

  function automatic logic [8*NB-1:0] put_byte(input logic [8*NB-1:0] blk,
                                               input int k, input logic [7:0] v);
    logic [8*NB-1:0] r;
    r = blk;
    r[8*(NB-1-k) +: 8] = v;
    return r;
  endfunction

  function automatic logic [8*NB-1:0] rand_block();
    logic [8*NB-1:0] r;
    for (int k = 0; k < NB; k++) r[8*k +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: stall byte 3 for 5 cycles
  task automatic run_block(input logic [8*NB-1:0] blk, input int mode, input bit noise);
    logic [11:0] expq[$];
    int  k, e, first_v, stall;
    bit  rdy, prev_stall;
    for (int i = 0; i < NB; i++) expq.push_back(ref_bcd(ref_byte(blk, i)));
    @(negedge clk);
    bus.start = 1'b1;
    bus.block_in = blk;
    bus.out_ready = 1'b1;
    k = 0; e = -1; first_v = -1; stall = 0; prev_stall = 1'b0;
    while (k < NB && e < 3000) begin
      @(negedge clk);
      e++;
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) bus.block_in = rand_block();
      chk("busy_in_block", 32'(bus.busy), 32'd1);
      chk("no_early_done", 32'(bus.done), 32'd0);
      if (prev_stall) chk("hold_valid", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        if (first_v < 0) begin
          first_v = e;
          chk("first_valid_latency", 32'(e), 32'd9);
        end
        chk("bcd_out", 32'(bus.bcd_out), 32'(expq[k]));
        chk("byte_idx", 32'(bus.byte_idx), 32'(k));
        if (mode == 1) rdy = 1'($urandom_range(0, 1));
        else if (mode == 2 && k == 3 && stall < 5) rdy = 1'b0;
        else rdy = 1'b1;
        if (!rdy) stall++;
        prev_stall = !rdy;
        bus.out_ready = rdy;
        if (rdy) k++;
      end else begin
        prev_stall = 1'b0;
        bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    chk("block_timeout", 32'(k), 32'(NB));
    if (mode == 2) chk("stall_cycles", 32'(stall), 32'd5);
    @(negedge clk);
    e++;
    bus.start = noise ? 1'b1 : 1'b0;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_in_done", 32'(bus.busy), 32'd1);
    chk("valid_after_last", 32'(bus.out_valid), 32'd0);
    if (mode == 0) chk("done_time", 32'(e), 32'd160);
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("stay_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [8*NB-1:0] blk;
    int e;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.block_in = '0;
    bus.out_ready = 1'b0;
`ifdef SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd", 32'(bus.bcd_out), 32'd0);
    chk("rst_idx", 32'(bus.byte_idx), 32'd0);
    rst = 1'b0;

    // Known corner values at the front of a block.
    blk = rand_block();
    blk = put_byte(blk, 0, 8'h00);
    blk = put_byte(blk, 1, 8'h09);
    blk = put_byte(blk, 2, 8'h0A);
    blk = put_byte(blk, 3, 8'h63);
    blk = put_byte(blk, 4, 8'h64);
    blk = put_byte(blk, 5, 8'hFF);
    blk = put_byte(blk, 6, 8'hC8);
    run_block(blk, 0, 1'b0);

    // Ordered block: byte_idx k carries value k.
    blk = 128'h000102030405060708090A0B0C0D0E0F;
    run_block(blk, 0, 1'b0);

    // Full 0..255 sweep; odd blocks with random ready and start/block noise.
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < NB; k++) blk = put_byte(blk, k, 8'(j * 16 + k));
      run_block(blk, (j % 2), 1'(j % 2));
    end

    // Backpressure on byte 3 = 0xC8.
    blk = put_byte(rand_block(), 3, 8'hC8);
    run_block(blk, 2, 1'b0);

    run_block(rand_block(), 1, 1'b1);

    // Reset during SHIFT of byte 7.
    blk = rand_block();
    @(negedge clk);
    bus.start = 1'b1;
    bus.block_in = blk;
    bus.out_ready = 1'b1;
    for (e = 0; e <= 73; e++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("pre_rst_idx", 32'(bus.byte_idx), 32'd7);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_bcd", 32'(bus.bcd_out), 32'd0);
    chk("midrst_idx", 32'(bus.byte_idx), 32'd0);
    repeat (20) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(bus.done), 32'd0);
    end
    run_block(rand_block(), 0, 1'b0);

`ifdef SEQ_ABORT_EN
    // Abort while byte 2 waits in OUT.
    blk = rand_block();
    @(negedge clk);
    bus.start = 1'b1;
    bus.block_in = blk;
    bus.out_ready = 1'b1;
    e = 0;
    while (e < 200) begin
      @(negedge clk);
      e++;
      bus.start = 1'b0;
      if (bus.out_valid && bus.byte_idx == 4'd2) break;
    end
    chk("abort_reach_byte2", 32'(bus.byte_idx), 32'd2);
    bus.out_ready = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_bcd_kept", 32'(bus.bcd_out), 32'(ref_bcd(ref_byte(blk, 2))));
    chk("abort_idx_kept", 32'(bus.byte_idx), 32'd2);
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    bus.out_ready = 1'b1;
    run_block(rand_block(), 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
